tk1_step_ctrl: RTL and testbench
================================

// Module: tk1_step_ctrl
// PURPOSE
//  Sequencer for the TK1 tweakey lane of the unrolled Skinny-128-384+ core. Loads TK1 once per
//  block, then advances it through the 8-round tweakey permutation (pt8, instantiated inside)
//  once per accepted step. Presents each step's TK1 to the round datapath over a valid/ready
//  handshake and signals completion after STEPS steps (40 rounds at default).
// PARAMETERS
//  STEPS  5                        round groups per block (8 rounds each); must be >= 1
//  CNT_W  (STEPS>1)?$clog2(STEPS):1  width of step counter
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      load tk1_in and begin a block; honoured in IDLE only
//  abort      in   1      synchronous cancel, any state
//  tk1_in     in   128    initial TK1 (LFSR counter || domain || zero pad)
//  tk1_out    out  128    TK1 for the current step
//  tk1_valid  out  1      tk1_out valid for the round datapath
//  tk1_ready  in   1      round datapath consumes tk1_out this cycle
//  step_idx   out  CNT_W  index of the step on tk1_out, 0..STEPS-1
//  last       out  1      tk1_valid && step_idx==STEPS-1
//  busy       out  1      state != IDLE
//  done       out  1      one-cycle pulse: block finished
//  rewind     in   1      only with TK1_REWIND_EN; see CONFIGURATION
// BEHAVIOUR
//  - Clock clk; reset is asynchronous, active-low (rst_n). Reset: state=IDLE, tk1_q=0,
//    step_cnt=0; all outputs 0.
//  - States: IDLE, RUN, DONE. tk1_out=tk1_q; step_idx=step_cnt; tk1_valid=(state==RUN).
//  - IDLE: start=1 -> tk1_q<=tk1_in, step_cnt<=0, RUN next cycle. Start-to-first-valid: 1 cycle.
//  - RUN, handshake (tk1_valid&&tk1_ready):
//      step_cnt<STEPS-1 -> tk1_q<=pt8(tk1_q), step_cnt<=step_cnt+1 (one step per cycle max);
//      step_cnt==STEPS-1 -> DONE; tk1_q and step_cnt hold.
//    No handshake: tk1_q and step_cnt hold; tk1_out stable while valid&&!ready.
//  - DONE: done=1, tk1_valid=0 for exactly one cycle, then IDLE. start in RUN/DONE ignored
//    (no queuing); start in the first IDLE cycle after DONE accepted.
//  - abort=1 (any state): next state IDLE, tk1_q<=0, step_cnt<=0, no done pulse. abort has
//    priority over start, handshake and rewind in the same cycle.
//  - STEPS==1: first handshake goes directly to DONE; pt8 result never registered.
//  - rst_n low mid-block: immediate return to reset values; no done.
//  - pt8 is purely combinational; the only register on the TK1 path is tk1_q (128 flops).
//  - Permutation has period 16, so pt8(pt8(x))==x: tk1_out alternates X, P8(X), X, ...
// CONFIGURATION
//  TK1_REWIND_EN defined: adds rewind port and 128-bit shadow register tk1_s, loaded with
//    tk1_in on accepted start. rewind=1 in IDLE (start=0) -> tk1_q<=tk1_s, step_cnt<=0, RUN;
//    re-runs the block without reload. rewind ignored in RUN/DONE; start wins over rewind in
//    IDLE; abort clears tk1_q and tk1_s to 0. Reset: tk1_s=0.
//  TK1_REWIND_EN undefined: no rewind port, no tk1_s; behaviour otherwise identical.
// TESTING
//  1. tk1_in=X=128'h000102..0F, start 1 cycle, tk1_ready=1 -> tk1_out X,P8(X),X,P8(X),X on
//     step_idx 0..4, last on step 4, done next cycle, busy low after.
//  2. Same load, tk1_ready low 3 cycles at step 2 -> tk1_out/step_idx held 3 cycles, valid
//     stays 1; completion delayed exactly 3 cycles.
//  3. abort asserted at step 3 -> IDLE next cycle, tk1_out=0, no done; start 1 cycle later
//     runs a fresh block with new tk1_in.
//  4. rst_n low at step 1 for 2 cycles -> all outputs 0 asynchronously, busy 0; start works
//     after release.
//  5. start pulsed during RUN and DONE with Y != X -> ignored; outputs keep X sequence.
//  6. TK1_REWIND_EN: after block with X, rewind in IDLE -> sequence X,P8(X),... repeats with
//     no start; rewind+start together loads tk1_in.

Source files
------------

// File: rtl/tk1_step_ctrl.sv
// TK1 tweakey lane sequencer for the unrolled Skinny-128-384+ core: loads TK1, then steps it
// through the 8-round tweakey permutation per accepted handshake. Optional: TK1_REWIND_EN.
module tk1_step_ctrl #(
  parameter int STEPS = 5,
  parameter int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [127:0]     tk1_in,
  output logic [127:0]     tk1_out,
  output logic             tk1_valid,
  input  logic             tk1_ready,
`ifdef TK1_REWIND_EN
  input  logic             rewind,
`endif
  output logic [CNT_W-1:0] step_idx,
  output logic             last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STEPS - 1);

  // Eight applications of the Skinny tweakey cell permutation collapse to a pairwise swap of
  // cells; cell 0 is the most significant byte.
  function automatic logic [127:0] pt8(input logic [127:0] x);
    pt8 = {x[87:80], x[79:72], x[103:96], x[111:104],
           x[71:64], x[127:120], x[119:112], x[95:88],
           x[23:16], x[15:8], x[39:32], x[47:40],
           x[7:0], x[63:56], x[55:48], x[31:24]};
  endfunction

  state_t           state_r, state_nxt_s;
  logic [127:0]     tk1_r, tk1_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             valid_r, last_r, busy_r, done_r;
`ifdef TK1_REWIND_EN
  logic [127:0]     shadow_r, shadow_nxt_s;
`endif

  // Next-state, TK1 and step-counter selection; abort overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    tk1_nxt_s   = tk1_r;
    cnt_nxt_s   = cnt_r;
`ifdef TK1_REWIND_EN
    shadow_nxt_s = shadow_r;
`endif
    if (abort) begin
      state_nxt_s = IDLE;
      tk1_nxt_s   = 128'd0;
      cnt_nxt_s   = {CNT_W{1'b0}};
`ifdef TK1_REWIND_EN
      shadow_nxt_s = 128'd0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nxt_s = RUN;
            tk1_nxt_s   = tk1_in;
            cnt_nxt_s   = {CNT_W{1'b0}};
`ifdef TK1_REWIND_EN
            shadow_nxt_s = tk1_in;
          end else if (rewind) begin
            state_nxt_s = RUN;
            tk1_nxt_s   = shadow_r;
            cnt_nxt_s   = {CNT_W{1'b0}};
`endif
          end else begin
            state_nxt_s = IDLE;
          end
        end
        RUN: begin
          if (tk1_ready) begin
            if (cnt_r == LAST_IDX) begin
              // Final step consumed: the permuted value is never registered.
              state_nxt_s = DONE;
            end else begin
              tk1_nxt_s = pt8(tk1_r);
              cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        DONE: begin
          state_nxt_s = IDLE;
        end
        default: begin
          state_nxt_s = IDLE;
          tk1_nxt_s   = 128'd0;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, TK1, counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      tk1_r   <= 128'd0;
      cnt_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tk1_r   <= tk1_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= (state_nxt_s == RUN);
      last_r  <= (state_nxt_s == RUN) && (cnt_nxt_s == LAST_IDX);
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
    end
  end

`ifdef TK1_REWIND_EN
  // Copy of the block's initial TK1 kept for rewind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= 128'd0;
    end else begin
      shadow_r <= shadow_nxt_s;
    end
  end
`endif

  assign tk1_out   = tk1_r;
  assign step_idx  = cnt_r;
  assign tk1_valid = valid_r;
  assign last      = last_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_tk1_step_ctrl.sv
// Self-checking bench for tk1_step_ctrl: directed vector table, corner-case sequences and
// randomized traffic against a behavioural model of the step sequence.
module tb_tk1_step_ctrl;
  localparam int STEPS = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, tk1_ready, rewind;
  logic [127:0]     tk1_in, tk1_out;
  logic             tk1_valid, last, busy, done;
  logic [CNT_W-1:0] step_idx;

  tk1_step_ctrl #(.STEPS(STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tk1_in(tk1_in),
    .tk1_out(tk1_out), .tk1_valid(tk1_valid), .tk1_ready(tk1_ready),
`ifdef TK1_REWIND_EN
    .rewind(rewind),
`endif
    .step_idx(step_idx), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] X_VAL  = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] PX_VAL = 128'h05060302070001040D0E0B0A0F08090C;
  localparam logic [127:0] Y_VAL  = 128'hA5A5A5A5_5A5A5A5A_12345678_9ABCDEF0;
  localparam logic [127:0] Z_VAL  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

  // Model: phase 0 idle, 1 running, 2 finished; k steps taken from base.
  int           m_ph = 0;
  int           m_k  = 0;
  logic [127:0] m_base = 128'd0;
  logic [127:0] m_shadow = 128'd0;

  // Skinny tweakey permutation applied eight times, cell by cell.
  function automatic logic [127:0] ref_p8(input logic [127:0] x);
    int pt[16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    logic [7:0] c[16];
    logic [7:0] t[16];
    for (int i = 0; i < 16; i++) c[i] = x[127 - 8*i -: 8];
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) t[i] = c[pt[i]];
      c = t;
    end
    for (int i = 0; i < 16; i++) ref_p8[127 - 8*i -: 8] = c[i];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_update();
    if (!rst_n || abort) begin
      m_ph = 0; m_k = 0; m_base = 128'd0; m_shadow = 128'd0;
    end else if (m_ph == 0) begin
      if (start) begin
        m_ph = 1; m_k = 0; m_base = tk1_in; m_shadow = tk1_in;
`ifdef TK1_REWIND_EN
      end else if (rewind) begin
        m_ph = 1; m_k = 0; m_base = m_shadow;
`endif
      end
    end else if (m_ph == 1) begin
      if (tk1_ready) begin
        if (m_k == STEPS - 1) m_ph = 2;
        else m_k++;
      end
    end else begin
      m_ph = 0;
    end
  endtask

  task automatic check_all();
    logic [127:0] e_tk;
    e_tk = (m_k % 2 == 1) ? ref_p8(m_base) : m_base;
    chk("tk1_out", tk1_out, e_tk);
    chk("tk1_valid", {127'd0, tk1_valid}, {127'd0, m_ph == 1});
    chk("step_idx", {125'd0, step_idx}, 128'(m_k));
    chk("last", {127'd0, last}, {127'd0, (m_ph == 1) && (m_k == STEPS - 1)});
    chk("busy", {127'd0, busy}, {127'd0, m_ph != 0});
    chk("done", {127'd0, done}, {127'd0, m_ph == 2});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  typedef struct {
    logic         st;
    logic         rdy;
    logic [127:0] tin;
    logic [127:0] e_tk;
    int           e_idx;
    logic         e_valid, e_last, e_busy, e_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tk1_ready = 1'b0; rewind = 1'b0;
    tk1_in = 128'd0;

    if (ref_p8(X_VAL) !== PX_VAL) $display("FAIL ref_p8 model %h", ref_p8(X_VAL));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tk1_out", tk1_out, 128'd0);
    chk("rst_flags", {123'd0, tk1_valid, last, busy, done, 1'b0}, 128'd0);
    chk("rst_idx", {125'd0, step_idx}, 128'd0);
    rst_n = 1'b1;

    // Directed 5-step block with ready held high
    vecs[0] = '{1'b1, 1'b1, X_VAL, X_VAL,  0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, X_VAL, PX_VAL, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, X_VAL, X_VAL,  2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, X_VAL, PX_VAL, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, X_VAL, X_VAL,  4, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, X_VAL, X_VAL,  4, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b1, X_VAL, X_VAL,  4, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      start = vecs[i].st; tk1_ready = vecs[i].rdy; tk1_in = vecs[i].tin;
      @(posedge clk);
      model_update();
      #1;
      chk("vec_tk1_out", tk1_out, vecs[i].e_tk);
      chk("vec_idx", {125'd0, step_idx}, 128'(vecs[i].e_idx));
      chk("vec_flags", {124'd0, tk1_valid, last, busy, done},
          {124'd0, vecs[i].e_valid, vecs[i].e_last, vecs[i].e_busy, vecs[i].e_done});
    end

    // Stall 3 cycles at step 2; completion slips by exactly 3
    start = 1'b1; tk1_ready = 1'b1; tk1_in = X_VAL;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    tk1_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_hold", {tk1_out, 1'b0}, {X_VAL, 1'b0});
      chk("stall_idx_valid", {124'd0, step_idx, tk1_valid}, {124'd0, 3'd2, 1'b1});
    end
    tk1_ready = 1'b1;
    cyc(); cyc();
    chk("stall_no_early_done", {127'd0, done}, 128'd0);
    cyc();
    chk("stall_done", {127'd0, done}, 128'd1);
    cyc();

    // Abort at step 3, then a fresh block
    start = 1'b1; tk1_in = X_VAL;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_tk1", tk1_out, 128'd0);
    chk("abort_busy_done", {126'd0, busy, done}, 128'd0);
    cyc();
    start = 1'b1; tk1_in = Z_VAL;
    cyc();
    start = 1'b0;
    chk("abort_restart", tk1_out, Z_VAL);
    repeat (6) cyc();

    // Asynchronous reset mid-block
    start = 1'b1; tk1_in = X_VAL;
    cyc();
    start = 1'b0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tk1", tk1_out, 128'd0);
    chk("async_rst_flags", {124'd0, tk1_valid, last, busy, done}, 128'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    start = 1'b1; tk1_in = Y_VAL;
    cyc();
    start = 1'b0;
    chk("post_rst_start", tk1_out, Y_VAL);
    repeat (6) cyc();

    // start ignored during RUN and DONE
    start = 1'b1; tk1_in = X_VAL;
    cyc();
    tk1_in = Y_VAL;
    cyc(); cyc();
    start = 1'b0;
    cyc(); cyc();
    chk("ign_last", {127'd0, last}, 128'd1);
    cyc();
    chk("ign_in_done", {127'd0, done}, 128'd1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("ign_after_done", {tk1_out, busy}, {X_VAL, 1'b0});
    cyc();

`ifdef TK1_REWIND_EN
    // Rewind replays the last loaded block; start wins over rewind
    rewind = 1'b1;
    cyc();
    rewind = 1'b0;
    chk("rewind_first", tk1_out, X_VAL);
    cyc();
    chk("rewind_second", tk1_out, PX_VAL);
    repeat (6) cyc();
    rewind = 1'b1; start = 1'b1; tk1_in = Z_VAL;
    cyc();
    rewind = 1'b0; start = 1'b0;
    chk("rewind_start", tk1_out, Z_VAL);
    repeat (6) cyc();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(3) == 0);
      abort     = ($urandom_range(15) == 0);
      tk1_ready = ($urandom_range(3) != 0);
      rewind    = ($urandom_range(5) == 0);
      tk1_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
